// File: rtl/fabric_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fabric_cfg_ctrl
// Description : Sequencer for a daisy-chained PE group. It clears the PEs,
//               streams CHAIN_LEN config words from a valid/ready host source
//               into the head of the configuration shift chain, runs the PEs
//               until every unmasked PE reports done, and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module fabric_cfg_ctrl #(
    parameter int CFG_WIDTH = 32,
    parameter int NUM_PE    = 16,
    parameter int CHAIN_LEN = 64,
    localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_PE-1:0]    pe_mask,
    input  logic                 cfg_s_valid,
    input  logic [CFG_WIDTH-1:0] cfg_s_data,
    output logic                 cfg_s_ready,
    output logic                 cfg_en,
    output logic [CFG_WIDTH-1:0] cfg_data,
    output logic                 ctrl_clear,
    output logic                 ctrl_en,
    input  logic [NUM_PE-1:0]    pe_done,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [31:0]          run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(CHAIN_LEN - 1);
    localparam logic [31:0]      c_RUN_MAX   = 32'hFFFF_FFFF;

    state_t              r_state;
    logic [NUM_PE-1:0]   r_mask;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [31:0]         r_run_cycles;
    logic                r_ctrl_clear;
    logic                r_ctrl_en;
    logic                r_done;
    logic                r_busy;

    logic                w_handshake;
    logic                w_all_done;

    // Host handshake: abort withdraws ready so an abort cycle never shifts.
    assign cfg_s_ready = (r_state == S_LOAD) & ~abort;
    assign w_handshake = cfg_s_valid & cfg_s_ready;
    assign cfg_en      = w_handshake;
    assign cfg_data    = w_handshake ? cfg_s_data : '0;

    // Masked-out PEs are treated as already done.
    assign w_all_done  = &(pe_done | ~r_mask);

    assign ctrl_clear  = r_ctrl_clear;
    assign ctrl_en     = r_ctrl_en;
    assign done        = r_done;
    assign busy        = r_busy;
    assign word_cnt    = r_word_cnt;
    assign run_cycles  = r_run_cycles;

    // Sequencer; the Moore outputs are registered alongside the next state so
    // each one is a clean flop that equals a decode of the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_word_cnt   <= '0;
            r_run_cycles <= '0;
            r_ctrl_clear <= 1'b0;
            r_ctrl_en    <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask       <= pe_mask;
                        r_state      <= S_CLEAR;
                        r_ctrl_clear <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_word_cnt   <= '0;
                    r_run_cycles <= '0;
                    if (abort) begin
                        // Stay in clear for the abort cycle's clear pulse.
                        r_state      <= S_ABORT;
                    end else begin
                        r_state      <= S_LOAD;
                        r_ctrl_clear <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state      <= S_ABORT;
                        r_ctrl_clear <= 1'b1;
                    end else if (w_handshake) begin
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                        if (r_word_cnt == c_LAST_WORD) begin
                            r_state   <= S_RUN;
                            r_ctrl_en <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state      <= S_ABORT;
                        r_ctrl_en    <= 1'b0;
                        r_ctrl_clear <= 1'b1;
                    end else begin
                        if (r_run_cycles != c_RUN_MAX) begin
                            r_run_cycles <= r_run_cycles + 32'd1;
                        end
                        if (w_all_done) begin
                            r_state   <= S_DONE;
                            r_ctrl_en <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                S_ABORT: begin
                    r_state      <= S_IDLE;
                    r_ctrl_clear <= 1'b0;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_ctrl_clear <= 1'b0;
                    r_ctrl_en    <= 1'b0;
                    r_done       <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fabric_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fabric_cfg_ctrl
// Description : Self-checking bench for fabric_cfg_ctrl. Each operation is
//               described as a transaction (words, valid pattern, per-PE done
//               times, abort point) and its cycle-by-cycle outcome is
//               predicted from those parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_cfg_ctrl;

    localparam int CFG_WIDTH = 32;
    localparam int NUM_PE    = 16;
    localparam int CHAIN_LEN = 64;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic [NUM_PE-1:0]    pe_mask;
    logic                 cfg_s_valid;
    logic [CFG_WIDTH-1:0] cfg_s_data;
    logic                 cfg_s_ready;
    logic                 cfg_en;
    logic [CFG_WIDTH-1:0] cfg_data;
    logic                 ctrl_clear;
    logic                 ctrl_en;
    logic [NUM_PE-1:0]    pe_done;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     word_cnt;
    logic [31:0]          run_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    fabric_cfg_ctrl #(
        .CFG_WIDTH (CFG_WIDTH),
        .NUM_PE    (NUM_PE),
        .CHAIN_LEN (CHAIN_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .pe_mask     (pe_mask),
        .cfg_s_valid (cfg_s_valid),
        .cfg_s_data  (cfg_s_data),
        .cfg_s_ready (cfg_s_ready),
        .cfg_en      (cfg_en),
        .cfg_data    (cfg_data),
        .ctrl_clear  (ctrl_clear),
        .ctrl_en     (ctrl_en),
        .pe_done     (pe_done),
        .busy        (busy),
        .done        (done),
        .word_cnt    (word_cnt),
        .run_cycles  (run_cycles)
    );

    // Free-running clock, active edge at posedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        abort       = 1'b0;
        cfg_s_valid = 1'b0;
        cfg_s_data  = '0;
        pe_done     = '0;
    endtask

    // One clear/load/run operation.
    //   valid_mode : 0 = valid always high, 1 = alternating 1/0, 2 = random
    //   abort_word : abort during LOAD when this many words are in (-1 = never)
    //   abort_run  : abort at a random RUN cycle
    //   fixed_t    : every PE done at this RUN index (-1 = random per PE)
    //   rst_in_run : assert rst_n asynchronously in the second RUN cycle
    task automatic do_op(input int valid_mode, input bit seq_words, input logic [NUM_PE-1:0] mask,
                         input int abort_word, input bit abort_run, input int fixed_t,
                         input bit rst_in_run);
        logic [CFG_WIDTH-1:0] words[CHAIN_LEN];
        int   t_done[NUM_PE];
        int   run_len;
        int   accepted;
        int   iters;
        int   abort_k;
        bit   v;
        bit   ab;
        logic [NUM_PE-1:0] pd;

        for (int i = 0; i < CHAIN_LEN; i++)
            words[i] = seq_words ? CFG_WIDTH'(i) : CFG_WIDTH'($urandom);
        run_len = 1;
        for (int i = 0; i < NUM_PE; i++) begin
            t_done[i] = (fixed_t >= 0) ? fixed_t : int'($urandom_range(0, 6));
            if (mask[i] && t_done[i] + 1 > run_len) run_len = t_done[i] + 1;
        end
        abort_k = abort_run ? int'($urandom_range(0, run_len - 1)) : -1;

        // start cycle (idle)
        idle_inputs();
        start   = 1'b1;
        pe_mask = mask;
        @(negedge clk);
        check_val("idle_busy", busy, 0);
        tick();

        // clear cycle; stray start and mask changes must be ignored
        start   = 1'($urandom % 2);
        pe_mask = NUM_PE'($urandom);
        @(negedge clk);
        check_val("clr_pulse", ctrl_clear, 1);
        check_val("clr_busy", busy, 1);
        check_val("clr_en", ctrl_en, 0);
        check_val("clr_ready", cfg_s_ready, 0);
        check_val("clr_cfg_en", cfg_en, 0);
        tick();

        // load phase
        accepted = 0;
        iters    = 0;
        while (accepted < CHAIN_LEN) begin
            case (valid_mode)
                0:       v = 1'b1;
                1:       v = (iters % 2) == 0;
                default: v = ($urandom % 10) < 7;
            endcase
            ab = (accepted == abort_word);
            if (ab) v = 1'b1;
            start       = ($urandom % 8) == 0;
            abort       = ab;
            cfg_s_valid = v;
            cfg_s_data  = v ? words[accepted] : CFG_WIDTH'($urandom);
            @(negedge clk);
            check_val("ld_ready", cfg_s_ready, !ab);
            check_val("ld_cfg_en", cfg_en, v && !ab);
            check_val("ld_cfg_data", cfg_data, (v && !ab) ? words[accepted] : 0);
            check_val("ld_word_cnt", word_cnt, accepted);
            check_val("ld_clear", ctrl_clear, 0);
            check_val("ld_ctrl_en", ctrl_en, 0);
            check_val("ld_busy", busy, 1);
            tick();
            iters++;
            if (ab) break;
            if (v) accepted++;
            if (iters > 1000) begin
                check_val("ld_timeout", iters, 0);
                break;
            end
        end
        if (valid_mode == 1 && abort_word < 0) check_val("ld_alt_cycles", iters, 2 * CHAIN_LEN - 1);

        // run phase
        if (accepted == CHAIN_LEN) begin
            for (int k = 0; k < run_len; k++) begin
                for (int i = 0; i < NUM_PE; i++)
                    pd[i] = mask[i] ? (k >= t_done[i]) : 1'($urandom);
                idle_inputs();
                start   = ($urandom % 4) == 0;
                pe_mask = NUM_PE'($urandom);
                pe_done = pd;
                abort   = (k == abort_k);
                cfg_s_valid = 1'($urandom);
                if (rst_in_run && k == 1) begin
                    #1 rst_n = 1'b0;
                    #1;
                    check_val("rst_busy", busy, 0);
                    check_val("rst_ctrl_en", ctrl_en, 0);
                    check_val("rst_clear", ctrl_clear, 0);
                    check_val("rst_done", done, 0);
                    check_val("rst_word_cnt", word_cnt, 0);
                    check_val("rst_run_cycles", run_cycles, 0);
                    check_val("rst_ready", cfg_s_ready, 0);
                    check_val("rst_cfg_en", cfg_en, 0);
                    idle_inputs();
                    tick();
                    tick();
                    rst_n = 1'b1;
                    return;
                end
                @(negedge clk);
                check_val("run_ctrl_en", ctrl_en, 1);
                check_val("run_clear", ctrl_clear, 0);
                check_val("run_done", done, 0);
                check_val("run_ready", cfg_s_ready, 0);
                check_val("run_cfg_en", cfg_en, 0);
                check_val("run_word_cnt", word_cnt, CHAIN_LEN);
                tick();
                if (k == abort_k) break;
            end
        end

        idle_inputs();
        if (abort_word >= 0 || abort_run) begin
            // abort cycle: clear pulse, no done
            abort = 1'($urandom);
            @(negedge clk);
            check_val("ab_clear", ctrl_clear, 1);
            check_val("ab_done", done, 0);
            check_val("ab_ctrl_en", ctrl_en, 0);
            check_val("ab_busy", busy, 1);
            check_val("ab_word_cnt", word_cnt, abort_word >= 0 ? abort_word : CHAIN_LEN);
            tick();
            idle_inputs();
            @(negedge clk);
            check_val("ab_idle_busy", busy, 0);
            check_val("ab_idle_clear", ctrl_clear, 0);
            check_val("ab_idle_done", done, 0);
            tick();
        end else begin
            // done cycle; abort here is ignored
            abort = 1'($urandom);
            @(negedge clk);
            check_val("dn_pulse", done, 1);
            check_val("dn_ctrl_en", ctrl_en, 0);
            check_val("dn_busy", busy, 1);
            check_val("dn_run_cycles", run_cycles, run_len);
            check_val("dn_word_cnt", word_cnt, CHAIN_LEN);
            tick();
            idle_inputs();
            @(negedge clk);
            check_val("post_done", done, 0);
            check_val("post_busy", busy, 0);
            check_val("post_clear", ctrl_clear, 0);
            check_val("post_run_cycles", run_cycles, run_len);
            check_val("post_word_cnt", word_cnt, CHAIN_LEN);
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        pe_mask = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_clear", ctrl_clear, 0);
        check_val("reset_ctrl_en", ctrl_en, 0);
        check_val("reset_word_cnt", word_cnt, 0);
        check_val("reset_run_cycles", run_cycles, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // words 0..63 back to back, all PEs done at RUN index 4 -> 5 cycles
        do_op(0, 1'b1, 16'hFFFF, -1, 1'b0, 4, 1'b0);
        // alternating valid
        do_op(1, 1'b0, 16'hFFFF, -1, 1'b0, -1, 1'b0);
        // partial mask, immediate exit on empty mask
        do_op(2, 1'b0, 16'h00FF, -1, 1'b0, -1, 1'b0);
        do_op(0, 1'b0, 16'h0000, -1, 1'b0, -1, 1'b0);
        // abort after 10 words, abort in run
        do_op(0, 1'b0, 16'hFFFF, 10, 1'b0, -1, 1'b0);
        do_op(2, 1'b0, 16'hF0F0, -1, 1'b1, -1, 1'b0);
        // async reset mid-run, then a normal operation
        do_op(0, 1'b0, 16'hFFFF, -1, 1'b0, 5, 1'b1);
        do_op(0, 1'b1, 16'hFFFF, -1, 1'b0, 4, 1'b0);
        // randomized operations
        for (int n = 0; n < 12; n++) begin
            int sel;
            sel = int'($urandom_range(0, 5));
            do_op(int'($urandom_range(0, 2)), 1'b0, NUM_PE'($urandom),
                  (sel == 0) ? int'($urandom_range(0, CHAIN_LEN - 1)) : -1,
                  sel == 1, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fabric_cfg_ctrl.md
# fabric_cfg_ctrl

Sequencer for a daisy-chained group of PE μcores. On `start` it clears the PEs, then streams `CHAIN_LEN` configuration words from a host valid/ready source into the head of the PE configuration shift chain. It then enables execution and waits until every unmasked PE reports done, counting run cycles, and pulses `done`. It sits between the host/config DMA and the PE array, driving each PE's `cfg_en`/`cfg_in` and `ctrl_en`/`ctrl_clear` and collecting `ctrl_done`.

## Interface
- `CFG_WIDTH`, 32, config word width (matches PE `cfg_in`)
- `NUM_PE`, 16, number of PEs whose `ctrl_done` is collected
- `CHAIN_LEN`, 64, words shifted per load (total chain depth); must be ≥1

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin clear+load+run; honoured only in IDLE
- `abort`  in  1  cancel any in-progress operation
- `pe_mask`  in  NUM_PE  1 = PE participates in done detection; sampled on accepted `start`
- `cfg_s_valid`  in  1  host config word valid
- `cfg_s_data`  in  CFG_WIDTH  host config word
- `cfg_s_ready`  out  1  controller accepts word
- `cfg_en`  out  1  shift enable to chain head and all PEs
- `cfg_data`  out  CFG_WIDTH  word into chain head
- `ctrl_clear`  out  1  clear to all PEs
- `ctrl_en`  out  1  run enable to all PEs
- `pe_done`  in  NUM_PE  per-PE `ctrl_done` levels
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `word_cnt`  out  $clog2(CHAIN_LEN+1)  words shifted in current load
- `run_cycles`  out  32  cycles spent in RUN, saturating

## Operation
- States: IDLE, CLEAR, LOAD, RUN, DONE, ABORT. Encoding is free.
- IDLE: on `start`, latch `pe_mask` into `mask_q` and go to CLEAR. `start` is ignored in all other states.
- CLEAR: drive `ctrl_clear`=1 for exactly one cycle. Zero `word_cnt` and `run_cycles`. Go to LOAD.
- LOAD:
  - `cfg_s_ready` = (state==LOAD) & !`abort`.
  - A handshake (valid & ready) combinationally drives `cfg_en`=1 and `cfg_data`=`cfg_s_data`, and increments `word_cnt`.
  - The handshake with `word_cnt`==CHAIN_LEN-1 goes to RUN.
  - Valid gaps stall the load with no shift.
- RUN:
  - `ctrl_en`=1; `run_cycles` increments each cycle and saturates at 0xFFFF_FFFF.
  - When &(`pe_done` | ~`mask_q`) is true in a RUN cycle, go to DONE. That cycle is counted.
  - `mask_q`==0 exits after 1 RUN cycle.
- DONE: `done`=1 for one cycle, then IDLE. `word_cnt` and `run_cycles` hold until the next CLEAR.
- ABORT:
  - `abort`=1 in CLEAR, LOAD or RUN goes to ABORT next cycle. `abort` beats a same-cycle handshake: no shift, no count.
  - ABORT drives `ctrl_clear`=1 for one cycle, then IDLE. No `done` pulse.
  - `abort` in IDLE or DONE is ignored; DONE still completes.
- `ctrl_clear`, `ctrl_en`, `done` and `busy` are Moore decodes of the registered state (glitch-free).
- `cfg_en`, `cfg_data` and `cfg_s_ready` are Mealy.
- When `cfg_en`=0, `cfg_data` = 0.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; `word_cnt`=0, `run_cycles`=0, `mask_q`=0.
- Reset mid-operation: immediate return to reset values; nothing partial is retained.
- `start` sampled at edge 0 → CLEAR in cycle 1 → LOAD from cycle 2.
- With `cfg_s_valid` held high, the last word is shifted in cycle CHAIN_LEN+1 and RUN starts at cycle CHAIN_LEN+2.
- RUN lasting N cycles → `done` in the following cycle → IDLE next.
- `pe_done` is used combinationally in the same cycle; no synchronizer (same clock domain).
- Minimum start-to-done latency with continuous valid and immediate done: CHAIN_LEN+3 cycles.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-RUN → all outputs 0 and `busy`=0 asynchronously; after release, `start` pulses produce a normal sequence.
- Full load, no gaps, CHAIN_LEN=64, words 0..63:
  - `cfg_en` high cycles 2..65 with `cfg_data`=0..63 in order.
  - `ctrl_clear` only in cycle 1; `ctrl_en` from cycle 66.
  - `pe_done`=all-ones at cycle 70 → `run_cycles`=5, `done` pulse at cycle 71.
- Bursty valid (alternating 1/0) → exactly 64 shifts over 127 cycles, `word_cnt`=64 at RUN entry, no shift on valid-low cycles.
- Masking: `pe_mask`=0x00FF latched at start, `pe_done`=0x00FF → DONE. Changing `pe_mask` during RUN has no effect. `pe_mask`=0 → `run_cycles`=1.
- Abort during LOAD after 10 words with valid high in the abort cycle → `word_cnt` stays 10, no `cfg_en` that cycle, `ctrl_clear` pulse next cycle, then IDLE, no `done`. Abort in RUN behaves the same.
- Saturation and ignored start: force a long RUN (or preload a test hook) → `run_cycles` sticks at 0xFFFF_FFFF. `start` pulses while `busy` → no restart, no extra `ctrl_clear`.
